// File: rtl/a2d_spi_resp_if.sv
// SPI link between the slider-polling master and the A2D responder.
// SCLK idles high; SS_n is active low.
interface a2d_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (
    output SS_n,
    output SCLK,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SS_n,
    input  SCLK,
    input  MOSI,
    output MISO
  );
endinterface

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D: command on MOSI, result of the
// previously commanded channel on MISO. Define A2D_CMD_CHK_EN to build the sticky cmd_err check.
module a2d_spi_resp #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned RES_W    = 12,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  a2d_spi_resp_if.slave           spi,
  input  logic [NUM_CH*RES_W-1:0] chan_vals,
  output logic [2:0]              cur_chnnl,
  output logic                    frame_done,
  output logic                    short_frame,
  output logic                    cmd_err
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  logic [SYNC_STG-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic                ss_prev_q, sclk_prev_q;
  logic                ss_s, sclk_s, mosi_s;
  logic                ss_rise, sclk_rise, sclk_fall;

  state_e      state_q;
  logic [15:0] tx_shft_q;
  logic [15:0] rx_shft_q;
  logic [4:0]  bit_cnt_q;
  logic [2:0]  cur_chnnl_q;
  logic        miso_q;
  logic        frame_done_q;
  logic        short_frame_q;
  logic [RES_W-1:0] ch_val;

  // Extra flop after the sync chain gives the previous level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STG-2:0], spi.SS_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], spi.SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], spi.MOSI};
      ss_prev_q   <= ss_sync_q[SYNC_STG-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STG-1];
    end
  end

  assign ss_s      = ss_sync_q[SYNC_STG-1];
  assign sclk_s    = sclk_sync_q[SYNC_STG-1];
  assign mosi_s    = mosi_sync_q[SYNC_STG-1];
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign ch_val = chan_vals[cur_chnnl_q*RES_W +: RES_W];

`ifdef A2D_CMD_CHK_EN
  logic cmd_err_q;
  assign cmd_err = cmd_err_q;
`else
  logic unused_rx;
  assign unused_rx = ^{rx_shft_q[15:14], rx_shft_q[10:0]};
  assign cmd_err   = 1'b0;
`endif

  logic unused_tx;
  assign unused_tx = tx_shft_q[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      tx_shft_q     <= '0;
      rx_shft_q     <= '0;
      bit_cnt_q     <= '0;
      cur_chnnl_q   <= '0;
      miso_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
`ifdef A2D_CMD_CHK_EN
      cmd_err_q     <= 1'b0;
`endif
    end else begin
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          miso_q <= 1'b0;
          // Level, not edge: a select that fell during StDone is still seen here.
          if (!ss_s) begin
            tx_shft_q <= {{(16-RES_W){1'b0}}, ch_val};
            bit_cnt_q <= '0;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (ss_rise) begin
            miso_q  <= 1'b0;
            state_q <= StDone;
          end else if (sclk_rise) begin
            rx_shft_q <= {rx_shft_q[14:0], mosi_s};
            if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
          end else if (sclk_fall && (bit_cnt_q != 5'd0)) begin
            tx_shft_q <= {tx_shft_q[14:0], 1'b0};
            miso_q    <= tx_shft_q[14];
          end
        end
        StDone: begin
          miso_q <= 1'b0;
          if (bit_cnt_q == 5'd16) begin
            cur_chnnl_q  <= rx_shft_q[13:11];
            frame_done_q <= 1'b1;
`ifdef A2D_CMD_CHK_EN
            if ((rx_shft_q[15:14] != 2'b00) || (rx_shft_q[10:0] != 11'h000)) cmd_err_q <= 1'b1;
`endif
          end else begin
            short_frame_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi.MISO    = miso_q;
  assign cur_chnnl   = cur_chnnl_q;
  assign frame_done  = frame_done_q;
  assign short_frame = short_frame_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: drives SPI frames at clk/32 and checks returned results,
// channel tracking, pulses, reset mid-frame and the optional command check.
module tb_a2d_spi_resp;
  localparam int unsigned NUM_CH = 8;
  localparam int unsigned RES_W  = 12;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH*RES_W-1:0] chan_vals;
  logic [2:0]              cur_chnnl;
  logic                    frame_done;
  logic                    short_frame;
  logic                    cmd_err;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int sf_cnt = 0;

  a2d_spi_resp_if spi_if ();

  a2d_spi_resp #(
    .NUM_CH   (NUM_CH),
    .RES_W    (RES_W),
    .SYNC_STG (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi_if),
    .chan_vals   (chan_vals),
    .cur_chnnl   (cur_chnnl),
    .frame_done  (frame_done),
    .short_frame (short_frame),
    .cmd_err     (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (short_frame) sf_cnt <= sf_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_start();
    @(negedge clk);
    spi_if.SS_n = 1'b0;
    wait_clk(8);
  endtask

  // Master changes MOSI on SCLK fall and samples MISO just before SCLK rise.
  task automatic spi_bits(input logic [15:0] word, input int n, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      spi_if.SCLK = 1'b0;
      spi_if.MOSI = word[15-i];
      wait_clk(16);
      rx = {rx[14:0], spi_if.MISO};
      spi_if.SCLK = 1'b1;
      wait_clk(16);
    end
  endtask

  task automatic spi_end();
    wait_clk(8);
    spi_if.SS_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic frame(input logic [15:0] word, input int n, output logic [15:0] rx);
    spi_start();
    spi_bits(word, n, rx);
    spi_end();
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    chan_vals[k*RES_W +: RES_W] = v;
  endtask

  initial begin
    logic [15:0] rx;
    int          fd0;
    int          sf0;
    int          prev;
    int          chs [6];
    chs = '{0, 1, 2, 3, 4, 7};

    rst_n       = 1'b0;
    spi_if.SS_n = 1'b1;
    spi_if.SCLK = 1'b1;
    spi_if.MOSI = 1'b0;
    chan_vals   = '0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(6);

    check("rst_miso", {31'd0, spi_if.MISO}, 32'd0);
    check("rst_cur", {29'd0, cur_chnnl}, 32'd0);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    check("rst_sf", {31'd0, short_frame}, 32'd0);
    check("rst_cmderr", {31'd0, cmd_err}, 32'd0);

    // Command ch3, then read it back; ch3 is changed mid-frame and must not leak in.
    set_ch(3, 12'hA5C);
    fd0 = fd_cnt;
    frame(16'h1800, 16, rx);
    check("f1_miso", {16'd0, rx}, 32'h0000);
    check("f1_cur", {29'd0, cur_chnnl}, 32'd3);
    check("f1_fd", fd_cnt - fd0, 32'd1);
    spi_start();
    set_ch(3, 12'hFFF);
    spi_bits(16'h1800, 16, rx);
    spi_end();
    check("f2_miso", {16'd0, rx}, 32'h0A5C);
    check("f2_fd", fd_cnt - fd0, 32'd2);

    // Pipelined poll: each frame returns the channel commanded by the frame before.
    for (int k = 0; k < 8; k++) set_ch(k, 12'(k * 12'h101));
    prev = 3;
    for (int i = 0; i < 6; i++) begin
      frame({2'b00, 3'(chs[i]), 11'h000}, 16, rx);
      check($sformatf("poll%0d_miso", i), {16'd0, rx}, 32'(prev * 12'h101));
      check($sformatf("poll%0d_cur", i), {29'd0, cur_chnnl}, 32'(chs[i]));
      prev = chs[i];
    end
    frame(16'h0000, 16, rx);
    check("poll_ch7_miso", {16'd0, rx}, 32'h0707);

    // Short frame of 9 bits.
    fd0 = fd_cnt;
    sf0 = sf_cnt;
    frame(16'h2000, 9, rx);
    check("short_sf", sf_cnt - sf0, 32'd1);
    check("short_fd", fd_cnt - fd0, 32'd0);
    check("short_cur", {29'd0, cur_chnnl}, 32'd0);
    frame(16'h2800, 16, rx);
    check("after_short_miso", {16'd0, rx}, 32'h0000);
    check("after_short_cur", {29'd0, cur_chnnl}, 32'd5);
    check("after_short_sf", sf_cnt - sf0, 32'd1);

    // Reset after 7 bits; ch5 word bit 9 is 1 so MISO is high just before reset.
    set_ch(5, 12'h2FF);
    set_ch(0, 12'h0F1);
    spi_start();
    spi_bits(16'h0000, 7, rx);
    wait_clk(8);
    check("pre_rst_miso", {31'd0, spi_if.MISO}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_miso", {31'd0, spi_if.MISO}, 32'd0);
    check("midrst_cur", {29'd0, cur_chnnl}, 32'd0);
    @(negedge clk);
    spi_if.SS_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(6);
    frame(16'h0000, 16, rx);
    check("post_rst_miso", {16'd0, rx}, 32'h00F1);

    // Malformed command: low bits set.
    frame(16'h1801, 16, rx);
    check("cmd_cur", {29'd0, cur_chnnl}, 32'd3);
`ifdef A2D_CMD_CHK_EN
    check("cmd_err_set", {31'd0, cmd_err}, 32'd1);
`else
    check("cmd_err_off", {31'd0, cmd_err}, 32'd0);
`endif
    frame(16'h1800, 16, rx);
    check("cmd_clean_miso", {16'd0, rx}, 32'h0303);
`ifdef A2D_CMD_CHK_EN
    check("cmd_err_sticky", {31'd0, cmd_err}, 32'd1);
`else
    check("cmd_err_still_off", {31'd0, cmd_err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a2d_spi_resp.md
Name: a2d_spi_resp

Overview:
- SPI responder that emulates the 8-channel, 12-bit A2D converter on the far end of the slider-polling link.
- Decodes the channel command sent on MOSI and returns the 12-bit conversion result on MISO.
- Used as a drop-in A2D model in full-chip simulation and in the FPGA loopback build.
- Channel values come from a flat input bus driven by the bench or by on-board test logic.

Parameters:
- NUM_CH, 8, number of channels; the command channel field is 3 bits.
- RES_W, 12, result width per channel.
- SYNC_STG, 2, synchronizer depth on SS_n, SCLK and MOSI.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  slave select from the master, active low
- SCLK  input  1  serial clock from the master, idles high
- MOSI  input  1  command data from the master
- MISO  output  1  result data to the master
- chan_vals  input  NUM_CH*RES_W  channel values; channel k occupies bits [k*RES_W +: RES_W]
- cur_chnnl  output  3  channel that will be returned in the next frame
- frame_done  output  1  one-clk pulse when a valid 16-bit frame completes
- short_frame  output  1  one-clk pulse when SS_n rises with bit count not equal to 16
- cmd_err  output  1  sticky command-format error (see Optional Feature)

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). All state flops reset asynchronously.
- Reset values:
  - MISO=0, cur_chnnl=0, frame_done=0, short_frame=0, cmd_err=0.
  - Shift registers and bit counter = 0; state = IDLE.
  - Synchronizers: SS_n stages=1, SCLK stages=1, MOSI stages=0.
- Input handling: SS_n, SCLK and MOSI pass through SYNC_STG flops. Edge detection runs on the last two stages.
- Timing requirement: SCLK high and low phases are each at least 4 clk. The host runs SCLK at clk/32.
- SPI mode: MOSI is sampled on SCLK rise. MISO shifts on SCLK fall. MSB goes first on both lines.
- Frame format:
  - MOSI word is {2'b00, chnnl[2:0], 11'h000}.
  - MISO word is {4'h0, result[11:0]}.
- States:
  - IDLE: on SS_n fall, load tx_shft = {4'h0, chan_vals[cur_chnnl]}, drive MISO = tx_shft[15] (0), clear bit_cnt, go to SHIFT.
  - SHIFT:
    - On SCLK rise: rx_shft = {rx_shft[14:0], MOSI}; bit_cnt++ (saturates at 31).
    - On SCLK fall with bit_cnt>0: tx_shft shifts left and MISO = new tx_shft[15].
    - On SS_n rise: go to DONE.
  - DONE (1 clk):
    - If bit_cnt==16: cur_chnnl = rx_shft[13:11], pulse frame_done.
    - Else: pulse short_frame and leave cur_chnnl unchanged.
    - Go to IDLE.
- Result semantics: each frame returns the value of the channel commanded by the PREVIOUS valid frame. The master's two-transaction sequence (command frame, then read frame) therefore reads the requested channel.
- chan_vals is sampled only at the SS_n fall. Changes mid-frame do not affect the frame in flight.
- MISO is held at 0 whenever the state is not SHIFT.
- Simultaneous SCLK edge and SS_n rise in the same clk: the SS_n rise wins, the edge is ignored, and the bit is not counted.
- SS_n fall while in DONE: taken in the following IDLE cycle. The synchronizer holds the level, so no frame is lost.
- Latency: MISO changes SYNC_STG+1 clk after the SCLK fall at the pin. frame_done asserts SYNC_STG+2 clk after SS_n rises at the pin.
- Reset mid-frame returns all outputs to reset values immediately. The master's partial frame is discarded.

Optional Feature:
- Macro: A2D_CMD_CHK_EN.
- When defined: in DONE for a valid frame, cmd_err sets and stays set until reset if rx_shft[15:14]!=0 or rx_shft[10:0]!=0. cur_chnnl still updates from bits [13:11].
- When not defined: cmd_err is tied 0 and no check logic is built.

Test Plan:
- Reset, then SS_n high with SCLK idle -> MISO=0, cur_chnnl=0, all pulses 0.
- chan_vals ch3=12'hA5C; frame with MOSI=16'h1800, then a second frame -> first frame MISO=16'h0000 (ch0 value 0); cur_chnnl=3 after first frame; second frame MISO=16'h0A5C; frame_done pulses once per frame.
- Poll channels 0,1,2,3,4,7 in the host's channel order, with ch k value = 12'h100*k+k -> each read returns the matching value; channel 7 returns 12'h707.
- SS_n low for only 9 SCLK cycles with MOSI=16'h2000 -> short_frame one pulse; cur_chnnl unchanged; next full frame behaves normally.
- Assert rst_n low after 7 bits of a frame -> MISO=0 and state IDLE immediately; the next full frame returns the ch0 value.
- With A2D_CMD_CHK_EN: MOSI=16'h1801 -> cmd_err=1 and remains set through later clean frames; cur_chnnl=3. Without the macro, cmd_err stays 0.
